// File: rtl/axi_xbar_1to2.sv
// axi_xbar_1to2: one upstream AXI4 master port routed to two slaves by address.
// S0 = main memory window, S1 = peripheral window, anything else gets DECERR
// from a local responder. A single transaction is in flight at a time, and the
// route stays locked from address acceptance to the final response handshake.
// Handshakes: a beat transfers on a rising clk edge where valid && ready;
// valid never waits on ready, and every valid/ready pair is forced to 0 in reset.
module axi_xbar_1to2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter logic [ADDR_W-1:0] S0_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK = 32'hF800_0000,
    parameter logic [ADDR_W-1:0] S1_BASE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_F000
) (
    input  logic                clk,
    input  logic                rst,
    // upstream (from arbiter)
    input  logic [ID_W-1:0]     up_arid,
    input  logic [ADDR_W-1:0]   up_araddr,
    input  logic [7:0]          up_arlen,
    input  logic [2:0]          up_arsize,
    input  logic [1:0]          up_arburst,
    input  logic                up_arvalid,
    output logic                up_arready,
    output logic [ID_W-1:0]     up_rid,
    output logic [DATA_W-1:0]   up_rdata,
    output logic [1:0]          up_rresp,
    output logic                up_rlast,
    output logic                up_rvalid,
    input  logic                up_rready,
    input  logic [ID_W-1:0]     up_awid,
    input  logic [ADDR_W-1:0]   up_awaddr,
    input  logic [7:0]          up_awlen,
    input  logic [2:0]          up_awsize,
    input  logic [1:0]          up_awburst,
    input  logic                up_awvalid,
    output logic                up_awready,
    input  logic [DATA_W-1:0]   up_wdata,
    input  logic [DATA_W/8-1:0] up_wstrb,
    input  logic                up_wlast,
    input  logic                up_wvalid,
    output logic                up_wready,
    output logic [ID_W-1:0]     up_bid,
    output logic [1:0]          up_bresp,
    output logic                up_bvalid,
    input  logic                up_bready,
    // slave 0 (memory)
    output logic [ID_W-1:0]     s0_arid,
    output logic [ADDR_W-1:0]   s0_araddr,
    output logic [7:0]          s0_arlen,
    output logic [2:0]          s0_arsize,
    output logic [1:0]          s0_arburst,
    output logic                s0_arvalid,
    input  logic                s0_arready,
    input  logic [ID_W-1:0]     s0_rid,
    input  logic [DATA_W-1:0]   s0_rdata,
    input  logic [1:0]          s0_rresp,
    input  logic                s0_rlast,
    input  logic                s0_rvalid,
    output logic                s0_rready,
    output logic [ID_W-1:0]     s0_awid,
    output logic [ADDR_W-1:0]   s0_awaddr,
    output logic [7:0]          s0_awlen,
    output logic [2:0]          s0_awsize,
    output logic [1:0]          s0_awburst,
    output logic                s0_awvalid,
    input  logic                s0_awready,
    output logic [DATA_W-1:0]   s0_wdata,
    output logic [DATA_W/8-1:0] s0_wstrb,
    output logic                s0_wlast,
    output logic                s0_wvalid,
    input  logic                s0_wready,
    input  logic [ID_W-1:0]     s0_bid,
    input  logic [1:0]          s0_bresp,
    input  logic                s0_bvalid,
    output logic                s0_bready,
    // slave 1 (peripherals)
    output logic [ID_W-1:0]     s1_arid,
    output logic [ADDR_W-1:0]   s1_araddr,
    output logic [7:0]          s1_arlen,
    output logic [2:0]          s1_arsize,
    output logic [1:0]          s1_arburst,
    output logic                s1_arvalid,
    input  logic                s1_arready,
    input  logic [ID_W-1:0]     s1_rid,
    input  logic [DATA_W-1:0]   s1_rdata,
    input  logic [1:0]          s1_rresp,
    input  logic                s1_rlast,
    input  logic                s1_rvalid,
    output logic                s1_rready,
    output logic [ID_W-1:0]     s1_awid,
    output logic [ADDR_W-1:0]   s1_awaddr,
    output logic [7:0]          s1_awlen,
    output logic [2:0]          s1_awsize,
    output logic [1:0]          s1_awburst,
    output logic                s1_awvalid,
    input  logic                s1_awready,
    output logic [DATA_W-1:0]   s1_wdata,
    output logic [DATA_W/8-1:0] s1_wstrb,
    output logic                s1_wlast,
    output logic                s1_wvalid,
    input  logic                s1_wready,
    input  logic [ID_W-1:0]     s1_bid,
    input  logic [1:0]          s1_bresp,
    input  logic                s1_bvalid,
    output logic                s1_bready,
    // current FSM state, for observation only
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_S0    = 3'd1,
        RD_S1    = 3'd2,
        RD_ERR   = 3'd3,
        WR_S0    = 3'd4,
        WR_S1    = 3'd5,
        WR_ERR_W = 3'd6,
        WR_ERR_B = 3'd7
    } state_t;

    typedef enum logic [1:0] {T_S0 = 2'd0, T_S1 = 2'd1, T_ERR = 2'd2} tgt_t;

    state_t          state, next;
    logic [7:0]      cnt;
    logic [7:0]      lat_len;
    logic [ID_W-1:0] lat_id;
    logic            ar_hs, aw_hs;
    logic            err_last;
    tgt_t            ar_tgt, aw_tgt;

    // S0 wins when both windows match
    function automatic tgt_t decode(input logic [ADDR_W-1:0] a);
        if ((a & S0_MASK) == S0_BASE)      return T_S0;
        else if ((a & S1_MASK) == S1_BASE) return T_S1;
        else                               return T_ERR;
    endfunction

    assign ar_tgt    = decode(up_araddr);
    assign aw_tgt    = decode(up_awaddr);
    assign err_last  = (cnt == lat_len);
    assign dbg_state = state;

    // state register, latched id/len and the DECERR read beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            lat_id  <= '0;
            lat_len <= 8'd0;
        end else begin
            state <= next;
            if (ar_hs) begin
                lat_id  <= up_arid;
                lat_len <= up_arlen;
            end else if (aw_hs) begin
                lat_id <= up_awid;
            end
            if (state == RD_ERR && up_rready)
                cnt <= err_last ? 8'd0 : cnt + 8'd1;
        end
    end

    // routing, local DECERR responder and next-state; everything 0 in reset
    always_comb begin
        next = state;
        ar_hs = 1'b0;
        aw_hs = 1'b0;
        up_arready = 1'b0; up_awready = 1'b0; up_wready = 1'b0;
        up_rid = '0; up_rdata = '0; up_rresp = 2'b00; up_rlast = 1'b0; up_rvalid = 1'b0;
        up_bid = '0; up_bresp = 2'b00; up_bvalid = 1'b0;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
        s0_arvalid = 1'b0; s0_rready = 1'b0;
        s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = '0; s0_awburst = '0;
        s0_awvalid = 1'b0; s0_wdata = '0; s0_wstrb = '0; s0_wlast = 1'b0;
        s0_wvalid = 1'b0; s0_bready = 1'b0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
        s1_arvalid = 1'b0; s1_rready = 1'b0;
        s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awsize = '0; s1_awburst = '0;
        s1_awvalid = 1'b0; s1_wdata = '0; s1_wstrb = '0; s1_wlast = 1'b0;
        s1_wvalid = 1'b0; s1_bready = 1'b0;

        if (!rst) begin
            // payloads go to both slaves; only the valids select the target
            s0_arid = up_arid; s0_araddr = up_araddr; s0_arlen = up_arlen;
            s0_arsize = up_arsize; s0_arburst = up_arburst;
            s1_arid = up_arid; s1_araddr = up_araddr; s1_arlen = up_arlen;
            s1_arsize = up_arsize; s1_arburst = up_arburst;
            s0_awid = up_awid; s0_awaddr = up_awaddr; s0_awlen = up_awlen;
            s0_awsize = up_awsize; s0_awburst = up_awburst;
            s1_awid = up_awid; s1_awaddr = up_awaddr; s1_awlen = up_awlen;
            s1_awsize = up_awsize; s1_awburst = up_awburst;
            s0_wdata = up_wdata; s0_wstrb = up_wstrb; s0_wlast = up_wlast;
            s1_wdata = up_wdata; s1_wstrb = up_wstrb; s1_wlast = up_wlast;

            unique case (state)
                IDLE: begin
                    if (up_arvalid) begin
                        unique case (ar_tgt)
                            T_S0: begin s0_arvalid = 1'b1; up_arready = s0_arready; end
                            T_S1: begin s1_arvalid = 1'b1; up_arready = s1_arready; end
                            default: up_arready = 1'b1;
                        endcase
                        ar_hs = up_arready;
                        if (ar_hs)
                            next = (ar_tgt == T_S0) ? RD_S0 :
                                   (ar_tgt == T_S1) ? RD_S1 : RD_ERR;
                    end else if (up_awvalid) begin
                        unique case (aw_tgt)
                            T_S0: begin
                                s0_awvalid = 1'b1; up_awready = s0_awready;
                                s0_wvalid = up_wvalid; up_wready = s0_wready;
                            end
                            T_S1: begin
                                s1_awvalid = 1'b1; up_awready = s1_awready;
                                s1_wvalid = up_wvalid; up_wready = s1_wready;
                            end
                            default: up_awready = 1'b1;
                        endcase
                        aw_hs = up_awready;
                        if (aw_hs)
                            next = (aw_tgt == T_S0) ? WR_S0 :
                                   (aw_tgt == T_S1) ? WR_S1 : WR_ERR_W;
                    end
                end
                RD_S0: begin
                    up_rid = s0_rid; up_rdata = s0_rdata; up_rresp = s0_rresp;
                    up_rlast = s0_rlast; up_rvalid = s0_rvalid; s0_rready = up_rready;
                    if (s0_rvalid && up_rready && s0_rlast) next = IDLE;
                end
                RD_S1: begin
                    up_rid = s1_rid; up_rdata = s1_rdata; up_rresp = s1_rresp;
                    up_rlast = s1_rlast; up_rvalid = s1_rvalid; s1_rready = up_rready;
                    if (s1_rvalid && up_rready && s1_rlast) next = IDLE;
                end
                RD_ERR: begin
                    up_rvalid = 1'b1; up_rresp = 2'b11; up_rid = lat_id;
                    up_rlast = err_last;
                    if (up_rready && err_last) next = IDLE;
                end
                WR_S0: begin
                    s0_wvalid = up_wvalid; up_wready = s0_wready;
                    up_bid = s0_bid; up_bresp = s0_bresp; up_bvalid = s0_bvalid;
                    s0_bready = up_bready;
                    if (s0_bvalid && up_bready) next = IDLE;
                end
                WR_S1: begin
                    s1_wvalid = up_wvalid; up_wready = s1_wready;
                    up_bid = s1_bid; up_bresp = s1_bresp; up_bvalid = s1_bvalid;
                    s1_bready = up_bready;
                    if (s1_bvalid && up_bready) next = IDLE;
                end
                WR_ERR_W: begin
                    up_wready = 1'b1;
                    if (up_wvalid && up_wlast) next = WR_ERR_B;
                end
                WR_ERR_B: begin
                    up_bvalid = 1'b1; up_bresp = 2'b11; up_bid = lat_id;
                    if (up_bready) next = IDLE;
                end
                default: next = IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_xbar_1to2.md
Name: axi_xbar_1to2

Overview:
- Address-decoding AXI4 crossbar placed directly downstream of the IFU/LSU arbiter.
- Takes the arbiter's single granted master port and routes each transaction to one of two slaves: S0 is main memory (SRAM/MROM) and S1 is the peripheral window (UART/CLINT).
- Unmapped addresses are answered locally with DECERR.
- One transaction in flight at a time. Routing is locked from address acceptance until the response handshake completes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, AXI id width
- S0_BASE, 32'h8000_0000, S0 base address
- S0_MASK, 32'hF800_0000, S0 match mask (128 MiB window)
- S1_BASE, 32'h1000_0000, S1 base address
- S1_MASK, 32'hFFFF_F000, S1 match mask (4 KiB window)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- axi_up  axi_if.slave  bundle  upstream port, driven by the arbiter
- axi_s0  axi_if.master  bundle  memory slave
- axi_s1  axi_if.master  bundle  peripheral slave

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
  - On reset: state=IDLE, beat counter=0, latched id=0.
  - Every output to every port is 0, including all valid/ready signals.
- Address decode (combinational):
  - hit0 = (addr & S0_MASK) == S0_BASE
  - hit1 = (addr & S1_MASK) == S1_BASE
  - If both hit, S0 wins. If neither hits, target=ERR.
- States: IDLE, RD_S0, RD_S1, RD_ERR, WR_S0, WR_S1, WR_ERR_W, WR_ERR_B.
- IDLE:
  - If up.arvalid: decode araddr and forward the AR channel combinationally to the target (arready returned from it). Reads take priority over writes.
  - Else if up.awvalid: decode awaddr and forward AW and W to the target.
  - On the AR or AW handshake (valid&ready at the clock edge), latch target and id, then enter the RD_* or WR_* state. Without a handshake, stay in IDLE; the decode re-evaluates every cycle.
  - Non-selected slaves see all valid/ready signals at 0.
- RD_S0 / RD_S1:
  - R channel of the chosen slave is passed to up. AR toward that slave is held at 0.
  - Return to IDLE on rvalid & rready & rlast.
- WR_S0 / WR_S1:
  - W and B channels of the chosen slave are passed through.
  - Return to IDLE on bvalid & bready.
  - W beats presented during the IDLE AW cycle are also forwarded.
- RD_ERR:
  - In IDLE, arready=1 for an unmapped AR. Latch arid and arlen.
  - Return arlen+1 beats with rdata=0, rresp=2'b11, rid=latched arid; rlast on the final beat.
  - Beat counter is 8 bits and advances only on rvalid&rready.
  - Return to IDLE after the final beat handshakes.
- WR_ERR_W:
  - awready=1 in IDLE for an unmapped AW; latch awid.
  - Hold wready=1 and discard data. On a wvalid&wlast handshake, enter WR_ERR_B.
- WR_ERR_B:
  - bvalid=1, bresp=2'b11, bid=latched awid.
  - Return to IDLE on bready.
- Latency:
  - Zero added cycles on all passthrough paths.
  - DECERR read: first beat at earliest the cycle after AR acceptance.
  - DECERR write: B at earliest the cycle after the wlast handshake.
- Simultaneous AR and AW in IDLE: read served first; AW stays unaccepted (awready=0) until a later IDLE cycle.
- Slave responses arriving while that slave is not selected: ignored (ready held 0). This is not expected under normal operation.
- Reset asserted mid-transaction: immediate return to IDLE, with all outputs 0 asynchronously.

Test Plan:
- AR araddr=0x8000_0010, arlen=0 from up; S0 returns rdata=0xDEADBEEF, rlast=1 -> up sees that data with rresp=0 in the same cycle; S1 arvalid stays 0; state is IDLE the next cycle.
- AW+W to 0x1000_03F8, wdata=0x41, wstrb=4'h1 -> S1 receives the write; S1 bvalid passes to up with bid matching awid; S0 sees no valid.
- AR to 0x0000_0000, arid=3, arlen=3 -> arready=1 immediately; 4 beats of rresp=2'b11 with rid=3 and rlast only on the 4th beat; rready throttled 1/0 -> no beats lost.
- AW to 0x2000_0000 followed by 2 W beats (wlast on the 2nd) -> wready=1 throughout; afterwards bresp=2'b11 once, with bid matching.
- Simultaneous arvalid (0x8000_0000) and awvalid (0x8000_0004) -> read completes first; the AW handshake occurs only after the return to IDLE.
- S0 read in flight; rst pulsed asynchronously between edges -> all outputs 0 immediately; after release, state=IDLE and a new AR is routed correctly.
